fb_arbiter: RTL and testbench
=============================

# fb_arbiter

- Arbitrates the single-port 8-bit × 256K framebuffer RAM between two requesters:
  - the HDMI scan-out path, which issues read addresses (`offset`) and consumes pixel color;
  - the processor, which reads and writes pixels.
- Display reads get strict priority, with fixed latency. Processor accesses use a req/ack handshake.
- Sits between `processor`, `DE10_Nano_HDMI_TX` and the framebuffer RAM in the top-level connection.

## Interface
Parameters:
- `ADDR_W`, 18: pixel address width.
- `DATA_W`, 8: pixel width.
- `STARVE_LIMIT`, 64: consecutive display-won cycles before the processor is forced a slot (guard build only).

Ports:
- `clk` in 1: system clock (`FPGA_CLK1_50`).
- `rst` in 1: reset, asynchronous, active-low.
- `disp_req` in 1: display read request, one per cycle max.
- `disp_addr` in ADDR_W: display pixel address.
- `disp_valid` out 1: display data valid pulse.
- `disp_data` out DATA_W: pixel returned to display.
- `cpu_req` in 1: processor request. Must be held with stable `cpu_we`/`cpu_addr`/`cpu_wdata` until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: processor address.
- `cpu_wdata` in DATA_W: processor write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out DATA_W: read data, valid with `cpu_ack`.
- `mem_addr` out ADDR_W: RAM address, registered.
- `mem_wdata` out DATA_W: RAM write data, registered.
- `mem_we` out 1: RAM write enable, registered.
- `mem_rdata` in DATA_W: RAM read data, synchronous, 1-cycle latency.
- `drop_cnt` out 16: saturating count of display requests not serviced.

## Operation
- Each cycle the arbiter picks at most one owner: DISP, CPU or none. The choice is registered onto the `mem_*` port.
- Default priority: `disp_req` always wins. The processor gets the port in any cycle with `disp_req`=0.
- Processor FSM:
  - C_IDLE: on `cpu_req`, go to C_PEND.
  - C_PEND: when granted, go to C_RD (read) or C_WR (write).
  - C_WR: `cpu_ack` pulses; go to C_IDLE.
  - C_RD: wait for the RAM return, then go to C_ACK.
  - C_ACK: `cpu_ack`=1 and `cpu_rdata` captured; go to C_IDLE.
  - Processor addressing is a grant only in C_PEND. A new `cpu_req` is only sampled in C_IDLE, so back-to-back requests cost at least one idle cycle.
- A 2-deep tag pipeline (owner, valid) follows each issued read, so returned `mem_rdata` is steered to the correct requester.
- `mem_we`=1 only in a cycle owned by a CPU write. Otherwise `mem_we`=0 and `mem_wdata` holds its last value.
- `drop_cnt` increments on every `disp_req` not granted and saturates at 0xFFFF. Without the guard it stays 0.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in C_IDLE;
  - tag pipeline invalid;
  - starvation counter 0.
- Reset asserted mid-transaction aborts it with no `cpu_ack`. The processor must re-request.
- Display latency is fixed at 3 cycles:
  - `disp_req` sampled at cycle N;
  - `mem_addr` driven in N+1;
  - `mem_rdata` in N+2;
  - `disp_valid`/`disp_data` in N+3.
- Display throughput: one read per cycle.
- CPU read: grant at cycle G → `cpu_ack` at G+3.
- CPU write: grant at G → `mem_we` in G+1 → `cpu_ack` in G+1.
- Simultaneous `disp_req` and a pending CPU request: display wins. The CPU stays in C_PEND with no timeout, unless the guard is built in.
- A write and a display read can never issue in the same cycle. A read following a write to the same address returns the new data.

## Configuration
- Macro `FB_ARB_STARVE_GUARD_EN`.
- Defined: a counter increments each cycle the FSM is in C_PEND and loses the port to the display.
  - When it reaches `STARVE_LIMIT`, the next cycle is granted to the CPU regardless of `disp_req`.
  - The counter clears on any CPU grant.
  - The display request in that cycle is dropped: no `disp_valid` 3 cycles later, and `drop_cnt` increments.
- Undefined: strict display priority, no counter, `drop_cnt` tied to 0.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release; `disp_req`=1, `disp_addr`=0x00010 with RAM[0x10]=0x5A → `disp_valid`=1, `disp_data`=0x5A exactly 3 cycles later.
- CPU write then read, display idle: write 0xC3 to 0x3FFFF → `mem_we` pulse and `cpu_ack` 1 cycle after grant. Read of 0x3FFFF → `cpu_ack` with `cpu_rdata`=0xC3 at grant+3.
- Contention: `disp_req` held high for 20 cycles with `cpu_req` pending → CPU stays in C_PEND, 20 `disp_valid` pulses arrive in order. CPU is acked 3 cycles after `disp_req` drops (read).
- Interleaved: alternate `disp_req` 1/0 while the CPU issues 4 reads → no data mis-steered, and every `disp_data` matches RAM at its address.
- Guard (`FB_ARB_STARVE_GUARD_EN`, `STARVE_LIMIT`=4): continuous `disp_req` plus a CPU read → CPU granted on the 5th cycle, one display return missing, `drop_cnt`=1.
- Reset mid-read: assert `rst` in C_RD → no `cpu_ack`, FSM in C_IDLE after release.

Source files
------------

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - framebuffer RAM arbiter between display scan-out and processor
//
// Purpose:
//   Shares one single-port synchronous framebuffer RAM between the HDMI
//   scan-out path (strict priority, fixed 3-cycle read latency) and the
//   processor (req/ack handshake, reads and writes).
//
// Optional feature macro: FB_ARB_STARVE_GUARD_EN
//   Defined   : a pending processor access that keeps losing to the display
//               is forced a slot after STARVE_LIMIT lost cycles; dropped display
//               requests are counted in drop_cnt.
//   Undefined : strict display priority, drop_cnt tied to 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   disp_req/disp_addr       display read request and pixel address
//   disp_valid/disp_data     display read return (3 cycles after request)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  processor request, held until cpu_ack
//   cpu_ack/cpu_rdata        processor completion pulse and read data
//   mem_addr/mem_wdata/mem_we  registered RAM command port
//   mem_rdata                RAM read data, one cycle after mem_addr
//   drop_cnt                 saturating count of display requests not serviced

module fb_arbiter #(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       drop_cnt
);

   typedef enum logic [2:0] {
      C_IDLE = 3'd0,
      C_PEND = 3'd1,
      C_RD   = 3'd2,
      C_WR   = 3'd3,
      C_ACK  = 3'd4
   } cpu_state_t;

   cpu_state_t state, state_nxt;

   logic force_cpu;
   logic cpu_grant;
   logic disp_grant;

   // Read tag pipeline: stage 0 is aligned with mem_addr, stage 1 with mem_rdata.
   logic tag0_valid, tag0_cpu;
   logic tag1_valid, tag1_cpu;

`ifdef FB_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   assign force_cpu = (state == C_PEND) && (starve_cnt >= SW'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         if (cpu_grant)
            starve_cnt <= '0;
         else if ((state == C_PEND) && disp_req && (starve_cnt != SW'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + 1'b1;
         if (disp_req && !disp_grant && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end
`else
   assign force_cpu = 1'b0;
   assign drop_cnt  = 16'd0;
`endif

   // A forced processor slot steals the cycle even when the display is asking.
   assign disp_grant = disp_req && !force_cpu;
   assign cpu_grant  = (state == C_PEND) && (!disp_req || force_cpu);

   always_comb begin
      state_nxt = state;
      cpu_ack   = 1'b0;
      case (state)
         C_IDLE: if (cpu_req) state_nxt = C_PEND;
         C_PEND: if (cpu_grant) state_nxt = cpu_we ? C_WR : C_RD;
         C_WR: begin
            cpu_ack   = 1'b1;
            state_nxt = C_IDLE;
         end
         C_RD: if (tag1_valid && tag1_cpu) state_nxt = C_ACK;
         C_ACK: begin
            cpu_ack   = 1'b1;
            state_nxt = C_IDLE;
         end
         default: state_nxt = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= C_IDLE;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         tag0_valid <= 1'b0;
         tag0_cpu   <= 1'b0;
         tag1_valid <= 1'b0;
         tag1_cpu   <= 1'b0;
         disp_valid <= 1'b0;
         disp_data  <= '0;
         cpu_rdata  <= '0;
      end else begin
         state  <= state_nxt;
         mem_we <= cpu_grant && cpu_we;
         if (disp_grant)
            mem_addr <= disp_addr;
         else if (cpu_grant)
            mem_addr <= cpu_addr;
         if (cpu_grant && cpu_we)
            mem_wdata <= cpu_wdata;

         // Writes return nothing, so only reads enter the tag pipeline.
         tag0_valid <= disp_grant || (cpu_grant && !cpu_we);
         tag0_cpu   <= cpu_grant;
         tag1_valid <= tag0_valid;
         tag1_cpu   <= tag0_cpu;

         disp_valid <= tag1_valid && !tag1_cpu;
         if (tag1_valid && !tag1_cpu)
            disp_data <= mem_rdata;
         if (tag1_valid && tag1_cpu)
            cpu_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard testbench for fb_arbiter

module tb_fb_arbiter;

   localparam int AW = 18;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic          disp_valid;
   logic [DW-1:0] disp_data;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata = '0;
   logic [15:0]   drop_cnt;

   fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_valid(disp_valid), .disp_data(disp_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Framebuffer RAM model: synchronous, one-cycle read latency.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
      logic          we;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t dq[$];
   exp_t cq[$];
   exp_t md, mc;
   logic [DW-1:0] wr_map [logic [AW-1:0]];

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
      return a[7:0] ^ {a[11:8], a[17:14]} ^ 8'h3C;
   endfunction

   function automatic logic [DW-1:0] exp_val(logic [AW-1:0] a);
      if (wr_map.exists(a)) return wr_map[a];
      return pat(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents a response.
   always @(negedge clk) begin
      if (rst) begin
         if (disp_valid) begin
            if (dq.size() == 0) chk("disp_unexpected", {31'd0, disp_valid}, 32'd0);
            else begin
               md = dq.pop_front();
               chk("disp_data", {24'd0, disp_data}, {24'd0, md.data});
               chk("disp_latency", cyc, md.cyc);
            end
         end
         if (cpu_ack) begin
            if (cq.size() == 0) chk("cpu_ack_unexpected", {31'd0, cpu_ack}, 32'd0);
            else begin
               mc = cq.pop_front();
               chk("cpu_ack_cycle", cyc, mc.cyc);
               if (mc.we) begin
                  chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
                  chk("wr_mem_addr", {14'd0, mem_addr}, {14'd0, mc.addr});
                  chk("wr_mem_wdata", {24'd0, mem_wdata}, {24'd0, mc.data});
               end else begin
                  chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, mc.data});
               end
            end
         end
         if (mem_we && !cpu_ack) chk("stray_mem_we", {31'd0, mem_we}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_disp(input logic req, input logic [AW-1:0] a, input logic push);
      exp_t e;
      disp_req  = req;
      disp_addr = a;
      if (req && push) begin
         e.data = exp_val(a); e.cyc = cyc + 3; e.we = 1'b0; e.addr = a;
         dq.push_back(e);
      end
   endtask

   task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int lat, input logic push);
      exp_t e;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      if (push) begin
         e.data = we ? wd : exp_val(a); e.cyc = cyc + lat; e.we = we; e.addr = a;
         cq.push_back(e);
      end
      if (we) wr_map[a] = wd;
   endtask

   task automatic cpu_wait();
      for (int i = 0; i < 60; i++) begin
         if (cpu_ack) begin
            cpu_req = 1'b0;
            return;
         end
         tick();
      end
      chk("cpu_ack_timeout", {31'd0, cpu_ack}, 32'd1);
      cpu_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = pat(i[AW-1:0]);
      ram[18'h00010]    = 8'h5A;
      wr_map[18'h00010] = 8'h5A;

      // Reset held with random inputs: every output must read 0.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         disp_req = 1'($urandom); disp_addr = AW'($urandom);
         cpu_req = 1'($urandom); cpu_we = 1'($urandom);
         cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
         @(negedge clk);
         chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
         chk("rst_disp_data", {24'd0, disp_data}, 32'd0);
         chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
         chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
         chk("rst_mem_addr", {14'd0, mem_addr}, 32'd0);
         chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
         chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
         chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      end
      tick();
      disp_req = 0; disp_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      rst = 1'b1;
      tick();

      // First display read: RAM[0x10]=0x5A returned 3 cycles later.
      drive_disp(1'b1, 18'h00010, 1'b1);
      tick();
      drive_disp(1'b0, '0, 1'b0);
      repeat (4) tick();

      // CPU write then read of the top address with the display idle.
      cpu_start(1'b1, 18'h3FFFF, 8'hC3, 2, 1'b1);
      tick(); cpu_wait(); tick();
      cpu_start(1'b0, 18'h3FFFF, 8'h00, 4, 1'b1);
      tick(); cpu_wait(); tick();

`ifndef FB_ARB_STARVE_GUARD_EN
      // Contention: display holds the port for 20 cycles, CPU read waits.
      cpu_start(1'b0, 18'h00123, 8'h00, 23, 1'b1);
      for (int i = 0; i < 20; i++) begin
         drive_disp(1'b1, AW'(18'h00200 + i), 1'b1);
         tick();
      end
      drive_disp(1'b0, '0, 1'b0);
      chk("contention_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      tick(); cpu_wait(); tick();
`endif

      // Interleaved: display alternates 0/1 while the CPU does 4 reads.
      for (int k = 0; k < 4; k++) begin
         cpu_start(1'b0, AW'(18'h01000 + k * 37), 8'h00, 5, 1'b1);
         for (int off = 0; off < 6; off++) begin
            drive_disp((off % 2) == 1, AW'(18'h02000 + k * 6 + off), 1'b1);
            tick();
         end
      end
      cpu_req = 1'b0;
      drive_disp(1'b0, '0, 1'b0);
      repeat (5) tick();

      // Display read after a CPU write to the same address sees the new data.
      cpu_start(1'b1, 18'h02001, 8'h77, 2, 1'b1);
      tick(); cpu_wait(); tick();
      drive_disp(1'b1, 18'h02001, 1'b1);
      tick();
      drive_disp(1'b0, '0, 1'b0);
      repeat (4) tick();

`ifdef FB_ARB_STARVE_GUARD_EN
      // Starvation guard: forced CPU slot on the 5th pending cycle.
      cpu_start(1'b0, 18'h00456, 8'h00, 8, 1'b1);
      for (int i = 0; i < 10; i++) begin
         drive_disp(1'b1, AW'(18'h03000 + i), i != 5);
         tick();
         if (cpu_ack) cpu_req = 1'b0;
      end
      drive_disp(1'b0, '0, 1'b0);
      if (cpu_req) cpu_wait();
      repeat (5) tick();
      chk("guard_drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif

      // Reset asserted while the CPU read is in C_RD: no ack, clean restart.
      cpu_start(1'b0, 18'h00777, 8'h00, 0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("midrst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
      chk("midrst_mem_addr", {14'd0, mem_addr}, 32'd0);
      chk("midrst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      repeat (4) tick();
      cpu_start(1'b0, 18'h00777, 8'h00, 4, 1'b1);
      tick(); cpu_wait(); tick();

      repeat (6) tick();
      chk("disp_queue_empty", dq.size(), 32'd0);
      chk("cpu_queue_empty", cq.size(), 32'd0);
`ifndef FB_ARB_STARVE_GUARD_EN
      chk("final_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
